// File: rtl/gpx_pkg.sv
// Constants and state encoding shared by the GPX result-buffer write and read sides.
package gpx_pkg;

  localparam int GPX_MAX_CNT = 300;
  localparam int GPX_ADDR_W  = 9;
  localparam int GPX_DATA_W  = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FILL    = 2'd2,
    DONE    = 2'd3
  } gpx_wr_state_e;

endpackage

// File: rtl/gpx_data_wr.sv
// Captures one shot's TDC result words into a fixed frame, zero-fills the rest,
// then pulses done so the read side can drain addresses 0..MAX_CNT-1.
module gpx_data_wr
  import gpx_pkg::*;
#(
  parameter int MAX_CNT = GPX_MAX_CNT,
  parameter int ADDR_W  = GPX_ADDR_W,
  parameter int DATA_W  = GPX_DATA_W
) (
  input  logic              clk_fpga,
  input  logic              rst_n,
  input  logic              in_re_start,
  input  logic              in_event_start,
  input  logic              in_data_vld,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_event_end,
  output logic              out_wr_e,
  output logic [ADDR_W-1:0] out_wr_addr,
  output logic [DATA_W-1:0] out_wr_data,
  output logic              out_gpx_one_event_done,
  output logic [ADDR_W-1:0] out_hit_cnt,
  output logic              out_overflow,
  output logic              out_busy
);

  localparam logic [ADDR_W-1:0] CNT_MAX  = ADDR_W'(MAX_CNT);
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(MAX_CNT - 1);

  gpx_wr_state_e     state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] hits;
  logic              store;
  logic [ADDR_W-1:0] cnt_acc;

  // Count after this cycle's word, so a word arriving with event_end is included.
  always_comb begin
    store   = in_data_vld && (cnt < CNT_MAX);
    cnt_acc = store ? cnt + 1'b1 : cnt;
  end

  assign out_busy = (state != IDLE);

  always_ff @(posedge clk_fpga or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= IDLE;
      cnt                    <= '0;
      hits                   <= '0;
      out_wr_e               <= 1'b0;
      out_wr_addr            <= '0;
      out_wr_data            <= '0;
      out_gpx_one_event_done <= 1'b0;
      out_hit_cnt            <= '0;
      out_overflow           <= 1'b0;
    end else begin
      out_wr_e               <= 1'b0;
      out_gpx_one_event_done <= 1'b0;
      if (in_re_start) begin
        state        <= IDLE;
        cnt          <= '0;
        out_overflow <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (in_event_start) begin
              state        <= CAPTURE;
              cnt          <= '0;
              out_overflow <= 1'b0;
            end
          end
          CAPTURE: begin
            if (store) begin
              out_wr_e    <= 1'b1;
              out_wr_addr <= cnt;
              out_wr_data <= in_data;
            end
            if (in_data_vld && !store) out_overflow <= 1'b1;
            cnt <= cnt_acc;
            if (in_event_end) begin
              hits  <= cnt_acc;
              state <= (cnt_acc < CNT_MAX) ? FILL : DONE;
            end
          end
          FILL: begin
            out_wr_e    <= 1'b1;
            out_wr_addr <= cnt;
            out_wr_data <= '0;
            cnt         <= cnt + 1'b1;
            if (cnt == CNT_LAST) state <= DONE;
          end
          DONE: begin
            out_gpx_one_event_done <= 1'b1;
            out_hit_cnt            <= hits;
            state                  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gpx_data_wr.sv
// Randomized frame scenarios for gpx_data_wr, checked against a frame-level model.
module tb_gpx_data_wr;
  import gpx_pkg::*;

  localparam int MAXC = GPX_MAX_CNT;
  localparam int AW   = GPX_ADDR_W;
  localparam int DW   = GPX_DATA_W;

  logic          clk_fpga = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_re_start = 1'b0;
  logic          in_event_start = 1'b0;
  logic          in_data_vld = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_event_end = 1'b0;
  logic          out_wr_e;
  logic [AW-1:0] out_wr_addr;
  logic [DW-1:0] out_wr_data;
  logic          out_gpx_one_event_done;
  logic [AW-1:0] out_hit_cnt;
  logic          out_overflow;
  logic          out_busy;

  gpx_data_wr dut (
    .clk_fpga(clk_fpga), .rst_n(rst_n), .in_re_start(in_re_start),
    .in_event_start(in_event_start), .in_data_vld(in_data_vld), .in_data(in_data),
    .in_event_end(in_event_end), .out_wr_e(out_wr_e), .out_wr_addr(out_wr_addr),
    .out_wr_data(out_wr_data), .out_gpx_one_event_done(out_gpx_one_event_done),
    .out_hit_cnt(out_hit_cnt), .out_overflow(out_overflow), .out_busy(out_busy)
  );

  always #5 clk_fpga = ~clk_fpga;

  int cyc = 0;
  always @(posedge clk_fpga) cyc <= cyc + 1;

  // Observed traffic, sampled mid-cycle.
  int          wq_addr[$];
  logic [DW-1:0] wq_data[$];
  int          wq_cyc[$];
  int          dq_cyc[$];
  logic [AW-1:0] dq_hit[$];
  logic        dq_ovf[$];

  always @(negedge clk_fpga) begin
    if (rst_n && out_wr_e) begin
      wq_addr.push_back(int'(out_wr_addr));
      wq_data.push_back(out_wr_data);
      wq_cyc.push_back(cyc);
    end
    if (rst_n && out_gpx_one_event_done) begin
      dq_cyc.push_back(cyc);
      dq_hit.push_back(out_hit_cnt);
      dq_ovf.push_back(out_overflow);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int last_hit = 0;

  task automatic tick();
    @(posedge clk_fpga); #1;
  endtask

  task automatic clear_mon();
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    dq_cyc.delete(); dq_hit.delete(); dq_ovf.delete();
  endtask

  // Runs a whole frame: n words (optional random gaps), event_end either with the
  // last word or on its own cycle, optional junk inputs while the frame finishes.
  task automatic run_frame(input string name, input int n, input bit gaps,
                           input bit end_with_last, input bit junk);
    logic [DW-1:0] words[$];
    logic [DW-1:0] exp;
    int end_cyc, stored, bad, first_bad, waited;
    bit fill_exp;
    clear_mon();
    in_event_start = 1'b1; tick(); in_event_start = 1'b0;
    n_checks++;
    if (out_overflow !== 1'b0) begin
      n_fail++; $display("FAIL %s ovf_clear: got %0b want 0", name, out_overflow);
    end
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g = int'($urandom_range(0, 2));
        for (int k = 0; k < g; k++) tick();
      end
      in_data_vld = 1'b1;
      in_data = (name == "five") ? DW'(32'hA0 + i) : DW'($urandom);
      words.push_back(in_data);
      if (end_with_last && i == n - 1) begin
        in_event_end = 1'b1; end_cyc = cyc;
      end
      tick();
      in_data_vld = 1'b0; in_event_end = 1'b0;
    end
    if (!(end_with_last && n > 0)) begin
      in_event_end = 1'b1; end_cyc = cyc; tick(); in_event_end = 1'b0;
    end
    stored = (n < MAXC) ? n : MAXC;
    fill_exp = (stored < MAXC);
    waited = 0;
    while (dq_cyc.size() == 0 && waited < 400) begin
      if (junk) begin
        in_event_start = (waited == 40);
        in_event_end   = (waited == 60);
        in_data_vld    = 1'($urandom);
        in_data        = DW'($urandom);
      end
      tick(); waited++;
    end
    in_event_start = 1'b0; in_event_end = 1'b0; in_data_vld = 1'b0;
    for (int k = 0; k < 6; k++) tick();

    n_checks++;
    if (wq_addr.size() !== MAXC) begin
      n_fail++; $display("FAIL %s write_count: got %0d want %0d", name, wq_addr.size(), MAXC);
    end
    bad = 0; first_bad = -1;
    for (int a = 0; a < wq_addr.size() && a < MAXC; a++) begin
      exp = (a < stored) ? words[a] : '0;
      if (wq_addr[a] !== a || wq_data[a] !== exp) begin
        bad++; if (first_bad < 0) first_bad = a;
      end
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL %s frame_content: %0d bad entries, first at %0d (addr %0d data %h want %h)",
               name, bad, first_bad, wq_addr[first_bad], wq_data[first_bad],
               (first_bad < stored) ? words[first_bad] : '0);
    end
    n_checks++;
    if (dq_cyc.size() !== 1) begin
      n_fail++; $display("FAIL %s done_pulses: got %0d want 1", name, dq_cyc.size());
    end
    if (dq_cyc.size() > 0) begin
      n_checks++;
      if (dq_hit[0] !== AW'(stored)) begin
        n_fail++; $display("FAIL %s hit_cnt: got %0d want %0d", name, dq_hit[0], stored);
      end
      n_checks++;
      if (dq_ovf[0] !== (n > MAXC)) begin
        n_fail++; $display("FAIL %s overflow: got %0b want %0b", name, dq_ovf[0], n > MAXC);
      end
      n_checks++;
      if (fill_exp && wq_cyc.size() > 0) begin
        if (dq_cyc[0] !== wq_cyc[wq_cyc.size()-1] + 1) begin
          n_fail++; $display("FAIL %s done_timing_fill: got cyc %0d want %0d", name,
                             dq_cyc[0], wq_cyc[wq_cyc.size()-1] + 1);
        end
      end else if (dq_cyc[0] !== end_cyc + 2) begin
        n_fail++; $display("FAIL %s done_timing_full: got cyc %0d want %0d", name,
                           dq_cyc[0], end_cyc + 2);
      end
    end
    n_checks++;
    if (out_busy !== 1'b0 || out_overflow !== (n > MAXC)) begin
      n_fail++; $display("FAIL %s idle_after: busy %0b ovf %0b want 0 %0b", name,
                         out_busy, out_overflow, n > MAXC);
    end
    last_hit = stored;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({out_wr_e, out_wr_addr, out_wr_data, out_gpx_one_event_done,
         out_hit_cnt, out_overflow, out_busy} !== '0) begin
      n_fail++; $display("FAIL reset_state: outputs not all zero (busy %0b hit %0d)",
                         out_busy, out_hit_cnt);
    end
    rst_n = 1'b1; tick(); tick();
  endtask

  task automatic test_reset_mid_capture();
    in_event_start = 1'b1; tick(); in_event_start = 1'b0;
    for (int i = 0; i < 57; i++) begin
      in_data_vld = 1'b1; in_data = DW'($urandom); tick();
    end
    in_data_vld = 1'b1; in_data = DW'($urandom);
    @(posedge clk_fpga); #2 rst_n = 1'b0; #1;
    in_data_vld = 1'b0;
    n_checks++;
    if ({out_wr_e, out_wr_addr, out_wr_data, out_gpx_one_event_done,
         out_hit_cnt, out_overflow, out_busy} !== '0) begin
      n_fail++; $display("FAIL reset_async: wr_e %0b addr %0d hit %0d busy %0b want all 0",
                         out_wr_e, out_wr_addr, out_hit_cnt, out_busy);
    end
    tick(); rst_n = 1'b1; tick();
    n_checks++;
    if (out_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_idle: busy %0b want 0", out_busy);
    end
    run_frame("after_reset", 3, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_restart_in_fill();
    int waited, wc, dc;
    run_frame("pre_restart", 7, 1'b1, 1'b0, 1'b0);
    clear_mon();
    in_event_start = 1'b1; tick(); in_event_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_data_vld = 1'b1; in_data = DW'($urandom); tick();
    end
    in_data_vld = 1'b0;
    in_event_end = 1'b1; tick(); in_event_end = 1'b0;
    waited = 0;
    while (!(out_wr_e && out_wr_addr == AW'(150)) && waited < 400) begin
      tick(); waited++;
    end
    n_checks++;
    if (waited >= 400) begin
      n_fail++; $display("FAIL restart_reach150: timeout, addr %0d want 150", out_wr_addr);
    end
    in_re_start = 1'b1; tick(); in_re_start = 1'b0;
    n_checks++;
    if (out_wr_e !== 1'b0 || out_busy !== 1'b0) begin
      n_fail++; $display("FAIL restart_stop: wr_e %0b busy %0b want 0 0", out_wr_e, out_busy);
    end
    wc = wq_addr.size();
    for (int k = 0; k < 350; k++) tick();
    dc = dq_cyc.size();
    n_checks++;
    if (dc !== 0 || wq_addr.size() !== wc) begin
      n_fail++; $display("FAIL restart_quiet: done %0d extra writes %0d want 0 0",
                         dc, wq_addr.size() - wc);
    end
    n_checks++;
    if (out_hit_cnt !== AW'(last_hit)) begin
      n_fail++; $display("FAIL restart_hit_hold: got %0d want %0d", out_hit_cnt, last_hit);
    end
  endtask

  initial begin
    tick(); tick();
    test_reset();
    run_frame("five", 5, 1'b0, 1'b0, 1'b0);
    run_frame("overflow302", 302, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (out_overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky: got %0b want 1", out_overflow);
    end
    run_frame("zero_hits_junk", 0, 1'b0, 1'b0, 1'b1);
    run_frame("end_with_300th", 300, 1'b0, 1'b1, 1'b0);
    run_frame("random_gaps", int'($urandom_range(1, 120)), 1'b1, 1'b0, 1'b1);
    run_frame("end_with_last", int'($urandom_range(1, 299)), 1'b1, 1'b1, 1'b0);
    test_restart_in_fill();
    test_reset_mid_capture();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
